sprite_motion_ctrl: RTL

Per-frame position and animation controller for the player sprite. It drives the renderer's pos_x, pos_y, par and enable inputs, and consumes the same x, y pixel coordinates the renderer sees. State updates once per video frame from button inputs: walk left/right, jump with a gravity FSM, and walk-cycle pose toggling. Sits between input conditioning and the sprite renderer in the VGA pipeline.

---
 rtl/sprite_pkg.sv | 8 +
 rtl/sprite_window_hit.sv | 21 ++
 rtl/sprite_motion_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: motion state encoding plus screen and sprite dimensions shared with the renderer
package sprite_pkg;
  typedef enum logic [1:0] {GROUND, RISE, FALL} motion_state_t;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int SPR_W = 32;
  localparam int SPR_H = 16;
endpackage

// File: rtl/sprite_window_hit.sv
// sprite_window_hit: combinational test of whether a pixel lies inside a sprite window
module sprite_window_hit
  import sprite_pkg::*;
#(
  parameter int W = SPR_W,
  parameter int H = SPR_H
) (
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic [9:0] pos_x_i,
  input  logic [9:0] pos_y_i,
  output logic       hit_o
);
  logic [10:0] xe, ye, px, py;
  assign xe = {1'b0, x_i};
  assign ye = {1'b0, y_i};
  assign px = {1'b0, pos_x_i};
  assign py = {1'b0, pos_y_i};
  // one-column offset matches the renderer's x-pos_x-1 indexing
  assign hit_o = (xe >= px + 11'd1) && (xe <= px + 11'(W)) && (ye >= py) && (ye < py + 11'(H));
endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame walk/jump/pose controller; define DOUBLE_JUMP_EN for one airborne re-jump
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = SPR_W,
  parameter int SPRITE_H = SPR_H,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 608,
  parameter int GROUND_Y = 400,
  parameter int START_X  = 100,
  parameter int STEP_X   = 2,
  parameter int JUMP_V0  = 8,
  parameter int GRAVITY  = 1,
  parameter int ANIM_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       par,
  output logic       enable
);
  localparam logic signed [10:0] STEP_S = 11'(STEP_X);
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] GND_S  = 11'(GROUND_Y);

  motion_state_t state_q, state_d;
  logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [5:0] vel_q, vel_d, fv;
  logic [7:0] anim_q, anim_d;
  logic par_q, par_d;
  logic go_r, go_l, walk;
  logic signed [10:0] px_s, nx_s, py_s, ry_s, fy_s;

  assign go_r = btn_right & ~btn_left;
  assign go_l = btn_left & ~btn_right;
  assign walk = go_r | go_l;
  assign px_s = signed'({1'b0, pos_x_q});
  assign nx_s = go_r ? px_s + STEP_S : go_l ? px_s - STEP_S : px_s;
  assign pos_x_d = nx_s > XMAX_S ? 10'(XMAX_S) : nx_s < XMIN_S ? 10'(XMIN_S) : nx_s[9:0];
  assign py_s = signed'({1'b0, pos_y_q});
  assign ry_s = py_s - signed'({5'b0, vel_q});
  assign fv   = vel_q + 6'(GRAVITY);
  assign fy_s = py_s + signed'({5'b0, fv});

`ifdef DOUBLE_JUMP_EN
  logic jump_prev_q, dj_used_q, dj_used_d, dj_fire;
`endif

  always_comb begin
    state_d = state_q;
    vel_d   = vel_q;
    pos_y_d = pos_y_q;
    case (state_q)
      GROUND: if (btn_jump) begin
        state_d = RISE;
        vel_d   = 6'(JUMP_V0);
      end
      RISE: begin
        pos_y_d = ry_s[10] ? 10'd0 : ry_s[9:0];
        vel_d   = vel_q > 6'(GRAVITY) ? vel_q - 6'(GRAVITY) : 6'd0;
        state_d = vel_q > 6'(GRAVITY) ? RISE : FALL;
      end
      FALL: begin
        pos_y_d = fy_s >= GND_S ? 10'(GROUND_Y) : fy_s[9:0];
        vel_d   = fy_s >= GND_S ? 6'd0 : fv;
        state_d = fy_s >= GND_S ? GROUND : FALL;
      end
      default: state_d = GROUND;
    endcase
`ifdef DOUBLE_JUMP_EN
    dj_fire = (state_q != GROUND) && btn_jump && !jump_prev_q && !dj_used_q;
    if (dj_fire) begin
      state_d = RISE;
      vel_d   = 6'(JUMP_V0);
      pos_y_d = pos_y_q;
    end
    dj_used_d = (state_d == GROUND) ? 1'b0 : (dj_used_q | dj_fire);
`endif
  end

  always_comb begin
    par_d  = (state_q != GROUND) ? 1'b1 : !walk ? 1'b0 : (anim_q == 8'(ANIM_DIV - 1)) ? ~par_q : par_q;
    anim_d = (state_q != GROUND || !walk || anim_q == 8'(ANIM_DIV - 1)) ? 8'd0 : anim_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GROUND;
      pos_x_q <= 10'(START_X);
      pos_y_q <= 10'(GROUND_Y);
      vel_q   <= '0;
      anim_q  <= '0;
      par_q   <= 1'b0;
    end else if (frame_tick) begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vel_q   <= vel_d;
      anim_q  <= anim_d;
      par_q   <= par_d;
    end
  end

`ifdef DOUBLE_JUMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_prev_q <= 1'b0;
      dj_used_q   <= 1'b0;
    end else if (frame_tick) begin
      jump_prev_q <= btn_jump;
      dj_used_q   <= dj_used_d;
    end
  end
`endif

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign par   = par_q;

  sprite_window_hit #(.W(SPRITE_W), .H(SPRITE_H)) u_hit (
    .x_i    (x),
    .y_i    (y),
    .pos_x_i(pos_x_q),
    .pos_y_i(pos_y_q),
    .hit_o  (enable)
  );
endmodule
